// File: rtl/pong_pkg.sv
// Shared paddle/screen constants and the direction and FSM encodings used by
// the paddle movement logic.
package pong_pkg;

  localparam int CW           = 11;
  localparam int PY_MIN_DEF   = 0;
  localparam int PY_MAX_DEF   = 400;
  localparam int PY_RESET_DEF = 200;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_PLUS  = 2'd1,
    DIR_MINUS = 2'd2
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLUS  = 2'd1,
    S_MINUS = 2'd2
  } state_e;

  // Requests are active-low; both-high and both-low both mean "no request".
  function automatic dir_e decode_dir(input logic p_s, input logic m_s);
    case ({p_s, m_s})
      2'b01:   return DIR_PLUS;
      2'b10:   return DIR_MINUS;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer; resets to 1 so an active-low request reads idle.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/paddle_mover.sv
// Turns the active-low plus/minus request pair into a rate-limited, clamped
// paddle Y coordinate with a two-speed acceleration.
module paddle_mover
  import pong_pkg::*;
#(
  parameter int STEP_DIV  = 416667,
  parameter int STEP      = 4,
  parameter int ACC_TICKS = 8,
  parameter int PY_MIN    = PY_MIN_DEF,
  parameter int PY_MAX    = PY_MAX_DEF,
  parameter int PY_RESET  = PY_RESET_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          center,
  input  logic          p,
  input  logic          m,
  output logic [CW-1:0] py,
  output logic          at_top,
  output logic          at_bot,
  output logic          moving
);

  localparam int AW    = CW + 1;
  localparam int DIV_W = $clog2(STEP_DIV);
  localparam int RUN_W = $clog2(ACC_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(ACC_TICKS);

  logic p_s, m_s;
  dir_e dir;

  sync2 u_sync_p (.clk(clk), .rst_n(rst_n), .d(p), .q(p_s));
  sync2 u_sync_m (.clk(clk), .rst_n(rst_n), .d(m), .q(m_s));

  assign dir = decode_dir(p_s, m_s);

  // Movement tick divider; free-runs while enabled, independent of the FSM.
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;

  assign tick = en && (tick_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tick_cnt <= '0;
    else if (center || !en)    tick_cnt <= '0;
    else if (tick)             tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + DIV_W'(1);
  end

  state_e state, state_n;

  // A reversal always falls back to IDLE first.
  always_comb begin
    state_n = state;
    if (center || !en) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (dir == DIR_PLUS)       state_n = S_PLUS;
          else if (dir == DIR_MINUS) state_n = S_MINUS;
        end
        S_PLUS:  if (dir != DIR_PLUS)  state_n = S_IDLE;
        S_MINUS: if (dir != DIR_MINUS) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      moving <= 1'b0;
    end else begin
      state  <= state_n;
      moving <= (state_n != S_IDLE);
    end
  end

  logic [RUN_W-1:0] run_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 run_cnt <= '0;
    else if (center || state == S_IDLE)         run_cnt <= '0;
    else if (tick && run_cnt < RUN_SAT)         run_cnt <= run_cnt + RUN_W'(1);
  end

  // Clamp arithmetic carries one guard bit so underflow shows up in the MSB.
  logic [AW-1:0] step_w, py_w, sum, diff;
  logic [CW-1:0] py_nxt;

  always_comb begin
    step_w = (run_cnt < RUN_SAT) ? AW'(STEP) : AW'(2 * STEP);
    py_w   = {1'b0, py};
    sum    = py_w + step_w;
    diff   = py_w - step_w;
    py_nxt = py;
    if (tick) begin
      case (state)
        S_PLUS:  py_nxt = (sum > AW'(PY_MAX)) ? CW'(PY_MAX) : sum[CW-1:0];
        S_MINUS: py_nxt = (diff[AW-1] || diff < AW'(PY_MIN)) ? CW'(PY_MIN)
                                                              : diff[CW-1:0];
        default: py_nxt = py;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      py <= CW'(PY_RESET);
    else if (center) py <= CW'(PY_RESET);
    else             py <= py_nxt;
  end

  assign at_top = (py == CW'(PY_MIN));
  assign at_bot = (py == CW'(PY_MAX));

endmodule

// File: tb/tb_paddle_mover.sv
// Table-driven bench for paddle_mover with a scoreboard of expected outputs.
module tb_paddle_mover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, center, p, m;
  logic [10:0] py;
  logic        at_top, at_bot, moving;

  paddle_mover #(
    .STEP_DIV(4), .STEP(2), .ACC_TICKS(3),
    .PY_MIN(0), .PY_MAX(20), .PY_RESET(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .center(center), .p(p), .m(m),
    .py(py), .at_top(at_top), .at_bot(at_bot), .moving(moving)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, center, p, m;
    int   n;
    bit   all;
    int   py;
    bit   mov, top, bot;
  } vec_t;

  typedef struct {
    string tag;
    int    py;
    bit    mov, top, bot;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic e, logic c, logic pp, logic mm, int n,
                              bit all, int epy, bit emov, bit etop, bit ebot);
    vec_t v;
    v.en = e; v.center = c; v.p = pp; v.m = mm; v.n = n; v.all = all;
    v.py = epy; v.mov = emov; v.top = etop; v.bot = ebot;
    return v;
  endfunction

  task automatic push_exp(string tag, int epy, bit emov, bit etop, bit ebot);
    exp_t e;
    e.tag = tag; e.py = epy; e.mov = emov; e.top = etop; e.bot = ebot;
    sbq.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: queue empty, nothing expected");
      return;
    end
    e = sbq.pop_front();
    if (py !== 11'(e.py) || moving !== e.mov || at_top !== e.top || at_bot !== e.bot) begin
      bad++;
      $display("FAIL %s: got py=%0d moving=%0b top=%0b bot=%0b, want py=%0d moving=%0b top=%0b bot=%0b",
               e.tag, py, moving, at_top, at_bot, e.py, e.mov, e.top, e.bot);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic e, logic c, logic pp, logic mm);
    en = e; center = c; p = pp; m = mm;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // idle hold, center flush, plus run to the bottom clamp
    vecs.push_back(mk(1,0,1,1,40,1, 10,0,0,0));
    vecs.push_back(mk(1,1,1,1, 3,0, 10,0,0,0));
    vecs.push_back(mk(1,0,0,1, 2,0, 10,0,0,0));
    vecs.push_back(mk(1,0,0,1, 1,0, 10,1,0,0));
    vecs.push_back(mk(1,0,0,1, 1,0, 12,1,0,0));
    vecs.push_back(mk(1,0,0,1, 4,0, 14,1,0,0));
    vecs.push_back(mk(1,0,0,1, 4,0, 16,1,0,0));
    vecs.push_back(mk(1,0,0,1, 4,0, 20,1,0,1));
    vecs.push_back(mk(1,0,0,1, 4,0, 20,1,0,1));
    // reversal through one IDLE cycle, then minus run to the top clamp
    vecs.push_back(mk(1,0,1,0, 2,0, 20,1,0,1));
    vecs.push_back(mk(1,0,1,0, 1,0, 20,0,0,1));
    vecs.push_back(mk(1,0,1,0, 1,0, 20,1,0,1));
    vecs.push_back(mk(1,0,1,0, 4,0, 18,1,0,0));
    vecs.push_back(mk(1,0,1,0, 4,0, 16,1,0,0));
    vecs.push_back(mk(1,0,1,0, 4,0, 14,1,0,0));
    vecs.push_back(mk(1,0,1,0, 4,0, 10,1,0,0));
    vecs.push_back(mk(1,0,1,0, 4,0,  6,1,0,0));
    vecs.push_back(mk(1,0,1,0, 4,0,  2,1,0,0));
    vecs.push_back(mk(1,0,1,0, 4,0,  0,1,1,0));
    vecs.push_back(mk(1,0,1,0, 4,0,  0,1,1,0));
    // both-low idle code, then disabled with a plus request
    vecs.push_back(mk(1,0,0,0, 2,0,  0,1,1,0));
    vecs.push_back(mk(1,0,0,0, 1,0,  0,0,1,0));
    vecs.push_back(mk(1,0,0,0,17,1,  0,0,1,0));
    vecs.push_back(mk(0,0,0,1,10,1,  0,0,1,0));
    // recenter, climb to 16, then center lands on a tick
    vecs.push_back(mk(1,1,1,1, 3,0, 10,0,0,0));
    vecs.push_back(mk(1,0,0,1, 2,0, 10,0,0,0));
    vecs.push_back(mk(1,0,0,1, 1,0, 10,1,0,0));
    vecs.push_back(mk(1,0,0,1, 1,0, 12,1,0,0));
    vecs.push_back(mk(1,0,0,1, 4,0, 14,1,0,0));
    vecs.push_back(mk(1,0,0,1, 4,0, 16,1,0,0));
    vecs.push_back(mk(1,0,0,1, 3,0, 16,1,0,0));
    vecs.push_back(mk(1,1,0,1, 1,0, 10,0,0,0));

    rst_n = 1'b0;
    drive(0, 0, 1, 1);
    #7;
    push_exp("reset", 10, 0, 0, 0);
    pop_chk();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].center, vecs[i].p, vecs[i].m);
      for (int k = 0; k < (vecs[i].all ? vecs[i].n : 1); k++)
        push_exp($sformatf("row%0d", i), vecs[i].py, vecs[i].mov, vecs[i].top, vecs[i].bot);
      for (int k = 0; k < vecs[i].n; k++) begin
        step();
        if (vecs[i].all) pop_chk();
      end
      if (!vecs[i].all) pop_chk();
      if (i == 23) begin
        total++;
        if (dut.tick_cnt !== '0) begin
          bad++;
          $display("FAIL tick_cnt_disabled: got %0d want 0", dut.tick_cnt);
        end
      end
      if (i == 31) begin
        total++;
        if (dut.run_cnt !== '0) begin
          bad++;
          $display("FAIL run_after_center: got %0d want 0", dut.run_cnt);
        end
      end
    end

    // plus request still held after center: move up to 14, then async reset
    drive(1, 0, 0, 1);
    push_exp("post_center_plus", 10, 1, 0, 0);
    step(); pop_chk();
    push_exp("post_center_12", 12, 1, 0, 0);
    repeat (3) step();
    pop_chk();
    push_exp("post_center_14", 14, 1, 0, 0);
    repeat (4) step();
    pop_chk();
    step();
    #3 rst_n = 1'b0;
    #1;
    push_exp("async_reset", 10, 0, 0, 0);
    pop_chk();
    #1 rst_n = 1'b1;
    push_exp("rel_sync", 10, 0, 0, 0);
    repeat (2) step();
    pop_chk();
    push_exp("rel_fsm", 10, 1, 0, 0);
    step(); pop_chk();
    push_exp("rel_first_move", 12, 1, 0, 0);
    step(); pop_chk();

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
